mcu_rst_gen: RTL and testbench

Parametrised system reset generator for the next-generation Cortex-M0 MCU subsystem. Replaces the fixed OR of processor, watchdog and lockup reset requests with an N-source, maskable, stretched reset sequencer. Produces staggered AHB and APB resets and keeps a sticky reset-cause record for software. Sits beside the clock controller in the MCU top level, in the FCLK domain.

---
 rtl/mcu_rst_pkg.sv | 28 ++
 rtl/mcu_rst_filter.sv | 28 ++
 rtl/mcu_rst_gen.sv | 134 +++++++++++++
 tb/tb_mcu_rst_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mcu_rst_pkg.sv
// Shared types and helpers for the MCU reset generator: sequencer state
// encoding, the power-on cause bit position for the default build, and a
// counter width helper.
package mcu_rst_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      PDLY = 2'd2
   } rst_state_e;

   // The power-on flag sits directly above the source bits in the cause
   // record; with the default four sources that is bit 4.
   localparam int POR_BIT = 4;

   // Smallest width that can hold the given non-negative value (at least 1).
   function automatic int cnt_width(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((value >> i) != 0) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/mcu_rst_filter.sv
// Per-source two-stage glitch filter for reset requests. A source passes
// only once it has been high on two consecutive FCLK cycles. Only used
// when the MCU_RST_GLITCH_FILTER_EN build option is defined.
module mcu_rst_filter
   import mcu_rst_pkg::*;
#(
   parameter int NUM_SRC = POR_BIT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] req_in,
   output logic [NUM_SRC-1:0] req_out
);

   logic [NUM_SRC-1:0] req_prev;

   // Remember last cycle's request levels; cleared by power-on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_prev <= '0;
      end else begin
         req_prev <= req_in;
      end
   end

   assign req_out = req_in & req_prev;

endmodule

// File: rtl/mcu_rst_gen.sv
// N-source maskable, stretched system reset sequencer for the Cortex-M0 MCU
// subsystem. Releases HRESETn_o HOLD_CYCLES cycles after the last request
// and PRESETn_o PRESET_DELAY cycles after that, and keeps a sticky record
// of reset causes. Build option MCU_RST_GLITCH_FILTER_EN inserts a
// two-cycle glitch filter on every request source.
module mcu_rst_gen
   import mcu_rst_pkg::*;
#(
   parameter int NUM_SRC      = POR_BIT,
   parameter int HOLD_CYCLES  = 16,
   parameter int PRESET_DELAY = 2,
   parameter int CNT_W        = 16
) (
   input  logic               FCLK,
   input  logic               PORESET,
   input  logic [NUM_SRC-1:0] rst_req,
   input  logic [NUM_SRC-1:0] rst_mask,
   input  logic               cause_clr,
   output logic               HRESETn_o,
   output logic               PRESETn_o,
   output logic [NUM_SRC:0]   rst_cause,
   output logic               rst_busy
);

   // pcnt holds "cycles left minus one" so that PRESETn_o rises exactly
   // PRESET_DELAY cycles after HRESETn_o.
   localparam int PDLY_LOAD_INT = (PRESET_DELAY > 0) ? PRESET_DELAY - 1 : 0;
   localparam int PCNT_W        = cnt_width(PDLY_LOAD_INT);

   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [PCNT_W-1:0] PDLY_LOAD = PCNT_W'(PDLY_LOAD_INT);
   localparam logic [NUM_SRC:0]  POR_CAUSE = {1'b1, {NUM_SRC{1'b0}}};

   logic [NUM_SRC-1:0] req_hit;
   logic               act;
   rst_state_e         state;
   rst_state_e         state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [PCNT_W-1:0]  pcnt;
   logic [PCNT_W-1:0]  pcnt_nxt;
   logic               hresetn_nxt;
   logic               presetn_nxt;
   logic [NUM_SRC:0]   cause_nxt;

`ifdef MCU_RST_GLITCH_FILTER_EN
   mcu_rst_filter #(
      .NUM_SRC (NUM_SRC)
   ) u_filter (
      .clk     (FCLK),
      .reset   (PORESET),
      .req_in  (rst_req & rst_mask),
      .req_out (req_hit)
   );
`else
   assign req_hit = rst_req & rst_mask;
`endif

   assign act = |req_hit;

   // Sequencer next state: enter/stretch HOLD on any request, count down the
   // hold, then the peripheral release delay, then return to IDLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pcnt_nxt  = pcnt;
      unique case (state)
         IDLE: begin
            if (act) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (act) begin
               cnt_nxt = HOLD_LOAD;
            end else if (cnt == CNT_W'(1)) begin
               if (PRESET_DELAY == 0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = PDLY;
                  pcnt_nxt  = PDLY_LOAD;
               end
            end else if (cnt > CNT_W'(1)) begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         PDLY: begin
            if (act) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end else if (pcnt == '0) begin
               state_nxt = IDLE;
            end else begin
               pcnt_nxt = pcnt - PCNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Reset outputs and cause record for the coming cycle; a new cause wins
   // over a simultaneous clear.
   always_comb begin
      hresetn_nxt = (state_nxt != HOLD);
      presetn_nxt = (state_nxt == IDLE);
      cause_nxt   = (cause_clr ? '0 : rst_cause) | {1'b0, req_hit};
   end

   // State, counters and registered outputs; power-on reset restarts a full
   // hold from any point and loads the power-on cause pattern.
   always_ff @(posedge FCLK) begin
      if (PORESET) begin
         state     <= HOLD;
         cnt       <= HOLD_LOAD;
         pcnt      <= '0;
         HRESETn_o <= 1'b0;
         PRESETn_o <= 1'b0;
         rst_busy  <= 1'b1;
         rst_cause <= POR_CAUSE;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pcnt      <= pcnt_nxt;
         HRESETn_o <= hresetn_nxt;
         PRESETn_o <= presetn_nxt;
         rst_busy  <= ~(hresetn_nxt & presetn_nxt);
         rst_cause <= cause_nxt;
      end
   end

endmodule

// File: tb/tb_mcu_rst_gen.sv
// Directed self-checking bench for mcu_rst_gen (4 sources, 16-cycle hold,
// 2-cycle peripheral delay). Expected outputs are queued as each cycle is
// driven and checked after the following clock edge.
module tb_mcu_rst_gen;

   localparam int NUM_SRC      = 4;
   localparam int HOLD_CYCLES  = 16;
   localparam int PRESET_DELAY = 2;

   typedef struct {
      logic               h;
      logic               p;
      logic               busy;
      logic [NUM_SRC:0]   cause;
      string              tag;
   } exp_t;

   logic               FCLK = 1'b0;
   logic               PORESET;
   logic [NUM_SRC-1:0] rst_req;
   logic [NUM_SRC-1:0] rst_mask;
   logic               cause_clr;
   logic               HRESETn_o;
   logic               PRESETn_o;
   logic [NUM_SRC:0]   rst_cause;
   logic               rst_busy;

   exp_t exp_q[$];
   int   assert_count = 0;
   int   fail_count   = 0;

   mcu_rst_gen #(
      .NUM_SRC      (NUM_SRC),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .PRESET_DELAY (PRESET_DELAY),
      .CNT_W        (16)
   ) dut (
      .FCLK      (FCLK),
      .PORESET   (PORESET),
      .rst_req   (rst_req),
      .rst_mask  (rst_mask),
      .cause_clr (cause_clr),
      .HRESETn_o (HRESETn_o),
      .PRESETn_o (PRESETn_o),
      .rst_cause (rst_cause),
      .rst_busy  (rst_busy)
   );

   // Free-running FCLK, 10 time-unit period.
   always #5 FCLK = ~FCLK;

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic checkOutput();
      exp_t e;
      assert_count++;
      assert (exp_q.size() > 0) else begin
         fail_count++;
         $error("[TB] FAIL scoreboard_empty observed 0 entries expected >0");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         assert_count++;
         assert (HRESETn_o === e.h) else begin
            fail_count++;
            $error("[TB] FAIL %s HRESETn_o observed %b expected %b", e.tag, HRESETn_o, e.h);
         end
         assert_count++;
         assert (PRESETn_o === e.p) else begin
            fail_count++;
            $error("[TB] FAIL %s PRESETn_o observed %b expected %b", e.tag, PRESETn_o, e.p);
         end
         assert_count++;
         assert (rst_busy === e.busy) else begin
            fail_count++;
            $error("[TB] FAIL %s rst_busy observed %b expected %b", e.tag, rst_busy, e.busy);
         end
         assert_count++;
         assert (rst_cause === e.cause) else begin
            fail_count++;
            $error("[TB] FAIL %s rst_cause observed %b expected %b", e.tag, rst_cause, e.cause);
         end
      end
   endtask

   // Drive one cycle of inputs, queue what the outputs must be after the
   // next edge, then check them 1 time unit past that edge.
   task automatic applyStimulus(input logic [NUM_SRC-1:0] req, input logic clr,
                                input logic por, input logic exp_h, input logic exp_p,
                                input logic [NUM_SRC:0] exp_cause, input string tag);
      exp_t e;
      rst_req   = req;
      cause_clr = clr;
      PORESET   = por;
      e.h     = exp_h;
      e.p     = exp_p;
      e.busy  = ~(exp_h & exp_p);
      e.cause = exp_cause;
      e.tag   = tag;
      exp_q.push_back(e);
      @(posedge FCLK);
      #1;
      checkOutput();
   endtask

   // After the edge that (re)loads the hold: 15 more low cycles, then
   // HRESETn_o high with PRESETn_o low for 2 cycles, then both high.
   task automatic runRelease(input logic [NUM_SRC:0] cause, input string tag);
      for (int i = 0; i < HOLD_CYCLES - 1; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, cause, {tag, "_hold"});
      for (int i = 0; i < PRESET_DELAY; i++) applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, cause, {tag, "_pdly"});
      applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1, cause, {tag, "_idle"});
   endtask

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of reset scenarios.
   initial begin
      rst_req   = '0;
      rst_mask  = 4'b1111;
      cause_clr = 1'b0;
      PORESET   = 1'b1;

      for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000, "por_active");
      runRelease(5'b10000, "por");
      applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000, "por_settled");

`ifdef MCU_RST_GLITCH_FILTER_EN
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000, "flt_glitch");
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000, "flt_glitch_after");
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10000, "flt_first");
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10100, "flt_second");
      runRelease(5'b10100, "flt");
`else
      applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10010, "pulse_assert");
      runRelease(5'b10010, "pulse");

      for (int i = 0; i < 40; i++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011, "stretch_req");
      runRelease(5'b10011, "stretch");

      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10111, "reentry_assert");
      for (int i = 0; i < HOLD_CYCLES - 1; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10111, "reentry_hold");
      applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10111, "reentry_pdly");
      applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10111, "reentry_back");
      runRelease(5'b10111, "reentry");

      rst_mask = 4'b0111;
      for (int i = 0; i < 3; i++) applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 5'b10111, "masked_src");
      rst_mask = 4'b1111;

      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, "clr_with_set");
      runRelease(5'b00010, "clr_set");
      applyStimulus('0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, "clr_alone");

      applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000, "por_mid_req");
      for (int i = 0; i < 5; i++) applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000, "por_mid_hold");
      applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b10000, "por_mid_assert");
      runRelease(5'b10000, "por_mid");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
